// File: rtl/neuron_buffer_pingpong_ctrl.sv
// neuron_buffer_pingpong_ctrl: ping-pong select and paced read/write addressing for neuron buffers N1/N2
module neuron_buffer_pingpong_ctrl #(
  parameter int A   = 7,
  parameter int LCW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           layer_start,
  input  logic [A:0]     rd_len,
  input  logic [A:0]     wr_len,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [A-1:0]   readBuffAddress,
  input  logic           wr_valid,
  output logic           wr_ready,
  output logic [A-1:0]   writeBuffAddress,
  output logic           swap_sel,
  output logic           busy,
  output logic           layer_done,
  output logic [LCW-1:0] layer_count
);
  typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;
  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};
  state_t         state_q, state_d;
  logic [A:0]     rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic [A:0]     rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [A-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic           swap_sel_q, swap_sel_d, layer_done_q, layer_done_d;
  logic           rd_valid_q, rd_valid_d, wr_ready_q, wr_ready_d;
  logic [LCW-1:0] layer_count_q, layer_count_d;
  logic           rd_fire, wr_fire;
  assign rd_fire = rd_valid_q & rd_ready;
  assign wr_fire = wr_ready_q & wr_valid;
  always_comb begin
    state_d       = state_q;
    rd_len_d      = rd_len_q;
    wr_len_d      = wr_len_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    swap_sel_d    = swap_sel_q;
    layer_count_d = layer_count_q;
    case (state_q)
      IDLE: if (layer_start) begin
        rd_len_d  = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
        wr_len_d  = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;
        rd_cnt_d  = '0;
        wr_cnt_d  = '0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        rd_cnt_d  = rd_fire ? rd_cnt_q + (A+1)'(1) : rd_cnt_q;
        wr_cnt_d  = wr_fire ? wr_cnt_q + (A+1)'(1) : wr_cnt_q;
        rd_addr_d = rd_fire ? rd_addr_q + A'(1) : rd_addr_q;
        wr_addr_d = wr_fire ? wr_addr_q + A'(1) : wr_addr_q;
        state_d   = (rd_cnt_d == rd_len_q && wr_cnt_d == wr_len_q) ? SWAP : RUN;
      end
      SWAP: begin
        swap_sel_d    = ~swap_sel_q;
        layer_count_d = layer_count_q + LCW'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d       = IDLE;
      rd_cnt_d      = '0;
      wr_cnt_d      = '0;
      rd_addr_d     = '0;
      wr_addr_d     = '0;
      swap_sel_d    = 1'b0;
      layer_count_d = layer_count_q;
    end
    // handshake outputs are registered from next-state values so they never follow inputs combinationally
    rd_valid_d   = (state_d == RUN) && (rd_cnt_d < rd_len_d);
    wr_ready_d   = (state_d == RUN) && (wr_cnt_d < wr_len_d);
    layer_done_d = (state_d == SWAP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_len_q      <= '0;
      wr_len_q      <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      swap_sel_q    <= 1'b0;
      layer_done_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_ready_q    <= 1'b0;
      layer_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_len_q      <= rd_len_d;
      wr_len_q      <= wr_len_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      swap_sel_q    <= swap_sel_d;
      layer_done_q  <= layer_done_d;
      rd_valid_q    <= rd_valid_d;
      wr_ready_q    <= wr_ready_d;
      layer_count_q <= layer_count_d;
    end
  end
  assign rd_valid         = rd_valid_q;
  assign wr_ready         = wr_ready_q;
  assign readBuffAddress  = rd_addr_q;
  assign writeBuffAddress = wr_addr_q;
  assign swap_sel         = swap_sel_q;
  assign busy             = (state_q != IDLE);
  assign layer_done       = layer_done_q;
  assign layer_count      = layer_count_q;
endmodule

// File: tb/tb_neuron_buffer_pingpong_ctrl.sv
// tb_neuron_buffer_pingpong_ctrl: directed checks of ping-pong sequencing, handshakes, saturation, clear and reset
module tb_neuron_buffer_pingpong_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, clear, layer_start, rd_ready, wr_valid;
  logic [7:0] rd_len, wr_len;
  logic       rd_valid, wr_ready, swap_sel, busy, layer_done;
  logic [6:0] rd_addr, wr_addr;
  logic [7:0] layer_count;
  int         n_vec = 0;
  int         n_err = 0;
  neuron_buffer_pingpong_ctrl #(.A(7), .LCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .layer_start(layer_start),
    .rd_len(rd_len), .wr_len(wr_len), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .readBuffAddress(rd_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .writeBuffAddress(wr_addr), .swap_sel(swap_sel), .busy(busy),
    .layer_done(layer_done), .layer_count(layer_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [7:0] r, input logic [7:0] w);
    rd_len = r;
    wr_len = w;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask
  int rd_pat [5] = '{1, 0, 1, 0, 1};
  int rd_exp [5] = '{0, 1, 1, 2, 2};
  initial begin
    rst_n = 1'b0; clear = 1'b0; layer_start = 1'b0;
    rd_ready = 1'b0; wr_valid = 1'b0; rd_len = '0; wr_len = '0;
    #12;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_sel", swap_sel, 0);
    chk("rst_count", layer_count, 0);
    chk("rst_rd_addr", rd_addr, 0);
    #10 rst_n = 1'b1;
    tick();
    // layer 1: 4 reads / 4 writes, streaming continuously
    rd_ready = 1'b1; wr_valid = 1'b1;
    start(8'd4, 8'd4);
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_addr0", rd_addr, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_rd_addr", rd_addr, i);
      chk("t1_wr_addr", wr_addr, i);
    end
    tick();
    chk("t1_done", layer_done, 1);
    chk("t1_swap_rd_valid", rd_valid, 0);
    chk("t1_swap_wr_ready", wr_ready, 0);
    chk("t1_swap_addr", rd_addr, 4);
    chk("t1_swap_sel_pre", swap_sel, 0);
    tick();
    chk("t1_done_pulse", layer_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_swap_sel", swap_sel, 1);
    chk("t1_count", layer_count, 1);
    // layer 2 back to back
    start(8'd2, 8'd2);
    tick(); tick();
    chk("t2_done", layer_done, 1);
    tick();
    chk("t2_swap_sel", swap_sel, 0);
    chk("t2_count", layer_count, 2);
    // layer 3: stalled reads, longer write stream
    rd_ready = 1'b0;
    start(8'd3, 8'd6);
    for (int i = 0; i < 5; i++) begin
      rd_ready = rd_pat[i][0];
      chk("t3_rd_addr", rd_addr, rd_exp[i]);
      chk("t3_rd_valid", rd_valid, 1);
      tick();
    end
    chk("t3_rd_end_valid", rd_valid, 0);
    chk("t3_rd_end_addr", rd_addr, 3);
    chk("t3_wr_addr5", wr_addr, 5);
    chk("t3_still_run", layer_done, 0);
    tick();
    chk("t3_done", layer_done, 1);
    chk("t3_wr_final", wr_addr, 6);
    tick();
    chk("t3_swap_sel", swap_sel, 1);
    chk("t3_count", layer_count, 3);
    // layer 4: zero lengths, plus a start during SWAP
    rd_ready = 1'b1;
    start(8'd0, 8'd0);
    chk("t4_busy", busy, 1);
    chk("t4_rd_valid", rd_valid, 0);
    chk("t4_wr_ready", wr_ready, 0);
    chk("t4_no_done", layer_done, 0);
    tick();
    chk("t4_done", layer_done, 1);
    layer_start = 1'b1; rd_len = 8'd3;
    tick();
    layer_start = 1'b0;
    chk("t4_start_in_swap", busy, 0);
    chk("t4_swap_sel", swap_sel, 0);
    chk("t4_count", layer_count, 4);
    // layer 5: oversized read length saturates to 128
    start(8'd200, 8'd0);
    for (int i = 0; i < 128; i++) begin
      chk("t5_rd_addr", rd_addr, i);
      tick();
    end
    chk("t5_done", layer_done, 1);
    chk("t5_wrap_addr", rd_addr, 0);
    chk("t5_no_extra", rd_valid, 0);
    chk("t5_wr_addr", wr_addr, 0);
    tick();
    chk("t5_swap_sel", swap_sel, 1);
    chk("t5_count", layer_count, 5);
    // clear mid-layer; an in-run start must be ignored
    wr_valid = 1'b0;
    start(8'd5, 8'd5);
    layer_start = 1'b1; rd_len = 8'd1;
    tick();
    layer_start = 1'b0;
    tick();
    chk("t6_ign_addr", rd_addr, 2);
    chk("t6_ign_valid", rd_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_swap_sel", swap_sel, 0);
    chk("t6_clr_valid", rd_valid, 0);
    chk("t6_clr_addr", rd_addr, 0);
    chk("t6_clr_done", layer_done, 0);
    chk("t6_clr_count", layer_count, 5);
    tick();
    chk("t6_clr_done2", layer_done, 0);
    chk("t6_clr_idle", busy, 0);
    // async reset mid-layer
    start(8'd5, 8'd5);
    tick(); tick();
    chk("t7_pre_addr", rd_addr, 2);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_addr", rd_addr, 0);
    chk("t7_rst_valid", rd_valid, 0);
    chk("t7_rst_count", layer_count, 0);
    chk("t7_rst_swap_sel", swap_sel, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("t7_idle_after", busy, 0);
    chk("t7_no_done", layer_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
